// File: rtl/mem_router_pkg.sv
// Shared types, register offsets and the address decoder for the memory-request router.
package mem_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SRAM,
        ST_EXT_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic [2:0] {
        RGN_GPIO,
        RGN_TIMER,
        RGN_SRAM,
        RGN_EXT,
        RGN_NONE
    } region_e;

    typedef enum logic {
        RSP_OK,
        RSP_ERR
    } resp_e;

    localparam logic [3:0]  GPIO_DIR_OFF   = 4'd0;
    localparam logic [3:0]  GPIO_OUT_OFF   = 4'd4;
    localparam logic [3:0]  GPIO_IN_OFF    = 4'd8;
    localparam logic [31:0] GPIO_BANK_SIZE = 32'd12;
    localparam logic [31:0] TIMER_SIZE     = 32'd4;

    // 33-bit compare so a window ending at 2^32 does not wrap to zero.
    function automatic logic in_window(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, size};
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    function automatic region_e decode(input logic [31:0] a,
                                       input logic [31:0] gpio_base,
                                       input logic [31:0] timer_addr,
                                       input logic [31:0] sram_base,
                                       input logic [31:0] sram_size,
                                       input logic [31:0] ext_base,
                                       input logic [31:0] ext_size);
        if (in_window(a, gpio_base, GPIO_BANK_SIZE)) return RGN_GPIO;
        if (in_window(a, timer_addr, TIMER_SIZE))    return RGN_TIMER;
        if (in_window(a, sram_base, sram_size))      return RGN_SRAM;
        if (in_window(a, ext_base, ext_size))        return RGN_EXT;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/mem_router_if.sv
// Core-side data-port bus of the router (Ibex/Vicuna style request/grant/response).
interface mem_router_if #(
    parameter int unsigned MEM_W = 32
) ();
    // Handshake: a request is taken in the cycle mem_req_i && mem_gnt_o; the master holds
    // its fields stable until then. Each taken request gets exactly one single-cycle
    // response, either mem_rvalid_o (mem_rdata_o meaningful for reads) or mem_err_o.
    logic               mem_req_i;
    logic               mem_we_i;
    logic [31:0]        mem_addr_i;
    logic [MEM_W/8-1:0] mem_be_i;
    logic [MEM_W-1:0]   mem_wdata_i;
    logic               mem_gnt_o;
    logic               mem_rvalid_o;
    logic               mem_err_o;
    logic [MEM_W-1:0]   mem_rdata_o;

    modport master (
        output mem_req_i, mem_we_i, mem_addr_i, mem_be_i, mem_wdata_i,
        input  mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o
    );

    modport slave (
        input  mem_req_i, mem_we_i, mem_addr_i, mem_be_i, mem_wdata_i,
        output mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o
    );
endinterface

// File: rtl/mem_router_gpio.sv
// GPIO register bank: DIR/OUT registers, 2-flop input synchroniser and combinational read mux.
module mem_router_gpio
    import mem_router_pkg::*;
#(
    parameter int unsigned MEM_W  = 32,
    parameter int unsigned GPIO_N = 10,
    localparam int unsigned BE_N  = (GPIO_N + 7) / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        off,
    input  logic [BE_N-1:0]   wr_be,
    input  logic [GPIO_N-1:0] wr_data,
    output logic [MEM_W-1:0]  rd_data,
    input  logic [GPIO_N-1:0] gpio_in_i,
    output logic [GPIO_N-1:0] gpio_out_o,
    output logic [GPIO_N-1:0] gpio_oe_o
);

    logic [GPIO_N-1:0] dir;
    logic [GPIO_N-1:0] out;
    logic [GPIO_N-1:0] sync1;
    logic [GPIO_N-1:0] sync2;
    logic [GPIO_N-1:0] wr_mask;

    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < GPIO_N; i++) begin
            wr_mask[i] = wr_be[i / 8];
        end
    end

    // DIR resets to all-inputs so no pad is driven until software asks for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir   <= '1;
            out   <= '0;
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpio_in_i;
            sync2 <= sync1;
            if (wr_en && off == GPIO_DIR_OFF) dir <= (dir & ~wr_mask) | (wr_data & wr_mask);
            if (wr_en && off == GPIO_OUT_OFF) out <= (out & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            GPIO_DIR_OFF: rd_data[GPIO_N-1:0] = dir;
            GPIO_OUT_OFF: rd_data[GPIO_N-1:0] = out;
            GPIO_IN_OFF:  rd_data[GPIO_N-1:0] = sync2;
            default:      rd_data = '0;
        endcase
    end

    assign gpio_out_o = out;
    assign gpio_oe_o  = ~dir;

endmodule

// File: rtl/mem_router.sv
// Single-outstanding memory-request router: decodes core requests to GPIO, timer, SRAM or external storage.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int unsigned MEM_W        = 32,
    parameter int unsigned GPIO_N       = 10,
    parameter logic [31:0] GPIO_BASE    = 32'h0000_0100,
    parameter logic [31:0] TIMER_ADDR   = 32'h0000_0200,
    parameter logic [31:0] SRAM_BASE    = 32'h0000_1000,
    parameter logic [31:0] SRAM_SIZE    = 32'h0000_1000,
    parameter logic [31:0] EXT_BASE     = 32'h0000_2000,
    parameter logic [31:0] EXT_SIZE     = 32'h0100_0000,
    parameter bit          EXT_WRITABLE = 1'b0,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_router_if.slave        bus,

    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [31:0]        sram_addr_o,
    output logic [MEM_W/8-1:0] sram_be_o,
    output logic [MEM_W-1:0]   sram_wdata_o,
    input  logic [MEM_W-1:0]   sram_rdata_i,

    output logic               ext_req_o,
    output logic               ext_we_o,
    output logic [31:0]        ext_addr_o,
    output logic [MEM_W/8-1:0] ext_be_o,
    output logic [MEM_W-1:0]   ext_wdata_o,
    input  logic               ext_ready_i,
    input  logic [MEM_W-1:0]   ext_rdata_i,

    output logic               timer_set_o,
    output logic [31:0]        timer_val_o,
    input  logic               timer_high_i,

    input  logic [GPIO_N-1:0]  gpio_in_i,
    output logic [GPIO_N-1:0]  gpio_out_o,
    output logic [GPIO_N-1:0]  gpio_oe_o,

    output state_e             dbg_state
);

    localparam int unsigned BE_W   = MEM_W / 8;
    localparam int unsigned GBE_N  = (GPIO_N + 7) / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    state_e             state;
    state_e             state_next;
    region_e            req_region;
    region_e            region_q;
    resp_e              req_resp;
    resp_e              resp_q;
    logic [3:0]         req_gpio_off;
    logic [3:0]         gpio_off_q;
    logic [31:0]        addr_q;
    logic               we_q;
    logic [BE_W-1:0]    be_q;
    logic [MEM_W-1:0]   wdata_q;
    logic [MEM_W-1:0]   data_q;
    logic [CNT_W-1:0]   cnt;
    logic               grant;
    logic               timed_out;
    logic               gpio_wr;
    logic               rvalid;
    logic [MEM_W-1:0]   gpio_rdata;
    logic [MEM_W-1:0]   rdata_mux;

    assign grant     = bus.mem_req_i && (state == ST_IDLE);
    assign timed_out = (cnt == CNT_W'(TIMEOUT));
    assign dbg_state = state;

    // Error conditions that are known from the request alone are resolved at grant time.
    always_comb begin
        req_region   = decode(bus.mem_addr_i, GPIO_BASE, TIMER_ADDR, SRAM_BASE, SRAM_SIZE,
                              EXT_BASE, EXT_SIZE);
        req_gpio_off = bus.mem_addr_i[3:0] - GPIO_BASE[3:0];
        req_resp     = RSP_OK;
        case (req_region)
            RGN_GPIO:  if (bus.mem_addr_i[1:0] != 2'b00 ||
                           (bus.mem_we_i && req_gpio_off == GPIO_IN_OFF)) req_resp = RSP_ERR;
            RGN_TIMER: if (bus.mem_addr_i[1:0] != 2'b00) req_resp = RSP_ERR;
            RGN_SRAM:  req_resp = RSP_OK;
            RGN_EXT:   if (bus.mem_we_i && !EXT_WRITABLE) req_resp = RSP_ERR;
            default:   req_resp = RSP_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    if (req_region == RGN_SRAM)                              state_next = ST_SRAM;
                    else if (req_region == RGN_EXT && req_resp == RSP_OK)    state_next = ST_EXT_WAIT;
                    else                                                     state_next = ST_RESP;
                end
            end
            ST_SRAM:     state_next = ST_RESP;
            ST_EXT_WAIT: if (ext_ready_i || timed_out) state_next = ST_RESP;
            ST_RESP:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            region_q   <= RGN_NONE;
            resp_q     <= RSP_OK;
            gpio_off_q <= '0;
        end else begin
            if (grant) begin
                addr_q     <= bus.mem_addr_i;
                we_q       <= bus.mem_we_i;
                be_q       <= bus.mem_be_i;
                wdata_q    <= bus.mem_wdata_i;
                region_q   <= req_region;
                resp_q     <= req_resp;
                gpio_off_q <= req_gpio_off;
            end
            // Ready wins over timeout in the same cycle; once out of EXT_WAIT ready is ignored.
            if (state == ST_EXT_WAIT) begin
                if (ext_ready_i) begin
                    data_q <= ext_rdata_i;
                    resp_q <= RSP_OK;
                end else if (timed_out) begin
                    resp_q <= RSP_ERR;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        cnt <= '0;
        else if (state == ST_EXT_WAIT)  cnt <= cnt + CNT_W'(1);
        else                            cnt <= '0;
    end

    always_comb begin
        sram_req_o   = (state == ST_SRAM);
        sram_we_o    = sram_req_o && we_q;
        sram_addr_o  = sram_req_o ? (addr_q - SRAM_BASE) : '0;
        sram_be_o    = sram_req_o ? be_q : '0;
        sram_wdata_o = sram_req_o ? wdata_q : '0;

        ext_req_o    = (state == ST_EXT_WAIT);
        ext_we_o     = ext_req_o && we_q;
        ext_addr_o   = ext_req_o ? (addr_q - EXT_BASE) : '0;
        ext_be_o     = ext_req_o ? be_q : '0;
        ext_wdata_o  = ext_req_o ? wdata_q : '0;

        timer_set_o  = (state == ST_RESP) && (region_q == RGN_TIMER) && we_q && (resp_q == RSP_OK);
        timer_val_o  = timer_set_o ? 32'(wdata_q) : '0;
        gpio_wr      = (state == ST_RESP) && (region_q == RGN_GPIO) && we_q && (resp_q == RSP_OK);

        case (region_q)
            RGN_GPIO:  rdata_mux = gpio_rdata;
            RGN_TIMER: rdata_mux = MEM_W'(timer_high_i);
            RGN_SRAM:  rdata_mux = sram_rdata_i;
            RGN_EXT:   rdata_mux = data_q;
            default:   rdata_mux = '0;
        endcase

        rvalid           = (state == ST_RESP) && (resp_q == RSP_OK);
        bus.mem_gnt_o    = grant;
        bus.mem_rvalid_o = rvalid;
        bus.mem_err_o    = (state == ST_RESP) && (resp_q == RSP_ERR);
        bus.mem_rdata_o  = (rvalid && !we_q) ? rdata_mux : '0;
    end

    mem_router_gpio #(
        .MEM_W  (MEM_W),
        .GPIO_N (GPIO_N)
    ) u_gpio (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (gpio_wr),
        .off        (gpio_off_q),
        .wr_be      (be_q[GBE_N-1:0]),
        .wr_data    (wdata_q[GPIO_N-1:0]),
        .rd_data    (gpio_rdata),
        .gpio_in_i  (gpio_in_i),
        .gpio_out_o (gpio_out_o),
        .gpio_oe_o  (gpio_oe_o)
    );

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: GPIO, timer, SRAM, external access, timeout and reset cases.
module tb_mem_router;
    import mem_router_pkg::*;

    logic        clk;
    logic        rst;
    logic        sram_req_o, sram_we_o;
    logic [31:0] sram_addr_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        ext_req_o, ext_we_o;
    logic [31:0] ext_addr_o;
    logic [3:0]  ext_be_o;
    logic [31:0] ext_wdata_o;
    logic        ext_ready_i;
    logic [31:0] ext_rdata_i;
    logic        timer_set_o;
    logic [31:0] timer_val_o;
    logic        timer_high_i;
    logic [9:0]  gpio_in_i, gpio_out_o, gpio_oe_o;
    state_e      dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] sram_mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_router_if #(.MEM_W(32)) bus ();

    mem_router #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sram_req_o   (sram_req_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_be_o    (sram_be_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i),
        .ext_req_o    (ext_req_o),
        .ext_we_o     (ext_we_o),
        .ext_addr_o   (ext_addr_o),
        .ext_be_o     (ext_be_o),
        .ext_wdata_o  (ext_wdata_o),
        .ext_ready_i  (ext_ready_i),
        .ext_rdata_i  (ext_rdata_i),
        .timer_set_o  (timer_set_o),
        .timer_val_o  (timer_val_o),
        .timer_high_i (timer_high_i),
        .gpio_in_i    (gpio_in_i),
        .gpio_out_o   (gpio_out_o),
        .gpio_oe_o    (gpio_oe_o),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Synchronous SRAM model: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (sram_req_o) begin
            if (sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_be_o[b]) sram_mem[sram_addr_o[11:2]][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
            end
            sram_rdata_i <= sram_mem[sram_addr_o[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Driver: present a request in an IDLE cycle (T), check grant, return in cycle T+1.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_addr_i  = addr;
        bus.mem_be_i    = be;
        bus.mem_wdata_i = wdata;
        #1;
        check({tag, "_gnt"}, 32'(bus.mem_gnt_o), 32'd1);
        @(posedge clk); #1;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_addr_i  = '0;
        bus.mem_be_i    = '0;
        bus.mem_wdata_i = '0;
    endtask

    // Scoreboard side: wait (bounded) for the response, check latency/kind, pop expected read data.
    task automatic wait_resp(input string tag, input int start_lat, input int exp_lat,
                             input logic exp_err, input logic chk_rd);
        int lat;
        lat = start_lat;
        while (!(bus.mem_rvalid_o || bus.mem_err_o) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(bus.mem_err_o), 32'(exp_err));
        check({tag, "_rvalid"}, 32'(bus.mem_rvalid_o), 32'(!exp_err));
        if (chk_rd) check({tag, "_rdata"}, bus.mem_rdata_o, exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin
        int hi;
        int lat;
        int n_resp;

        rst = 1'b1;
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
        bus.mem_be_i = '0; bus.mem_wdata_i = '0;
        ext_ready_i = 1'b0; ext_rdata_i = '0; timer_high_i = 1'b0; gpio_in_i = '0;
        sram_rdata_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        check("rst_rvalid", 32'(bus.mem_rvalid_o), 32'd0);
        check("rst_err",    32'(bus.mem_err_o), 32'd0);
        check("rst_rdata",  bus.mem_rdata_o, 32'd0);
        check("rst_sram",   32'(sram_req_o), 32'd0);
        check("rst_ext",    32'(ext_req_o), 32'd0);
        check("rst_timer",  32'(timer_set_o), 32'd0);
        check("rst_oe",     32'(gpio_oe_o), 32'd0);
        check("rst_out",    32'(gpio_out_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // GPIO registers
        issue("gpio_dir_wr", 1'b1, 32'h0000_0100, 4'hF, 32'h0000_0003);
        wait_resp("gpio_dir_wr", 1, 1, 1'b0, 1'b0);
        check("gpio_oe", 32'(gpio_oe_o), 32'h0000_03FC);
        issue("gpio_out_wr", 1'b1, 32'h0000_0104, 4'hF, 32'h0000_0001);
        wait_resp("gpio_out_wr", 1, 1, 1'b0, 1'b0);
        check("gpio_out", 32'(gpio_out_o), 32'h0000_0001);
        exp_q.push_back(32'h0000_0001);
        issue("gpio_out_rd", 1'b0, 32'h0000_0104, 4'hF, 32'h0);
        wait_resp("gpio_out_rd", 1, 1, 1'b0, 1'b1);
        issue("gpio_be_wr", 1'b1, 32'h0000_0104, 4'h1, 32'hFFFF_FFFF);
        wait_resp("gpio_be_wr", 1, 1, 1'b0, 1'b0);
        check("gpio_out_be", 32'(gpio_out_o), 32'h0000_00FF);
        exp_q.push_back(32'h0000_0003);
        issue("gpio_dir_rd", 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        wait_resp("gpio_dir_rd", 1, 1, 1'b0, 1'b1);

        // GPIO input synchroniser: first read is too early to see the pad change
        gpio_in_i = 10'h2AA;
        exp_q.push_back(32'h0000_0000);
        issue("gpio_in_early", 1'b0, 32'h0000_0108, 4'hF, 32'h0);
        wait_resp("gpio_in_early", 1, 1, 1'b0, 1'b1);
        exp_q.push_back(32'h0000_02AA);
        issue("gpio_in_rd", 1'b0, 32'h0000_0108, 4'hF, 32'h0);
        wait_resp("gpio_in_rd", 1, 1, 1'b0, 1'b1);
        issue("gpio_in_wr", 1'b1, 32'h0000_0108, 4'hF, 32'h1);
        wait_resp("gpio_in_wr", 1, 1, 1'b1, 1'b0);

        // SRAM
        issue("sram_wr", 1'b1, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF);
        check("sram_wr_req",   32'(sram_req_o), 32'd1);
        check("sram_wr_we",    32'(sram_we_o), 32'd1);
        check("sram_wr_addr",  sram_addr_o, 32'h0000_0004);
        check("sram_wr_wdata", sram_wdata_o, 32'hDEAD_BEEF);
        wait_resp("sram_wr", 1, 2, 1'b0, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        issue("sram_rd", 1'b0, 32'h0000_1004, 4'hF, 32'h0);
        check("sram_rd_addr", sram_addr_o, 32'h0000_0004);
        check("sram_rd_we",   32'(sram_we_o), 32'd0);
        wait_resp("sram_rd", 1, 2, 1'b0, 1'b1);

        // EXT read, ready five cycles after ext_req_o rises
        exp_q.push_back(32'h0000_1234);
        issue("ext_rd", 1'b0, 32'h0000_2010, 4'hF, 32'h0);
        check("ext_rd_req",  32'(ext_req_o), 32'd1);
        check("ext_rd_addr", ext_addr_o, 32'h0000_0010);
        repeat (4) begin @(posedge clk); #1; end
        check("ext_rd_hold", 32'(ext_req_o), 32'd1);
        @(posedge clk); #1;
        check("ext_rd_noresp", 32'(bus.mem_rvalid_o), 32'd0);
        ext_ready_i = 1'b1; ext_rdata_i = 32'h0000_1234;
        @(posedge clk); #1;
        ext_ready_i = 1'b0; ext_rdata_i = '0;
        check("ext_rd_drop", 32'(ext_req_o), 32'd0);
        wait_resp("ext_rd", 7, 7, 1'b0, 1'b1);

        // EXT write while protected
        issue("ext_wr", 1'b1, 32'h0000_2000, 4'hF, 32'h5555_AAAA);
        check("ext_wr_noreq", 32'(ext_req_o), 32'd0);
        wait_resp("ext_wr", 1, 1, 1'b1, 1'b0);

        // EXT timeout: response at T+TIMEOUT+2, ext_req_o high T+1..T+TIMEOUT+1
        issue("ext_to", 1'b0, 32'h0000_2020, 4'hF, 32'h0);
        hi = 0;
        lat = 1;
        while (!(bus.mem_rvalid_o || bus.mem_err_o) && lat < 50) begin
            if (ext_req_o) hi++;
            @(posedge clk); #1;
            lat++;
        end
        check("ext_to_reqcyc", 32'(hi), 32'd9);
        check("ext_to_reqlow", 32'(ext_req_o), 32'd0);
        wait_resp("ext_to", lat, 10, 1'b1, 1'b0);

        // Late ready is ignored, next request is served normally at minimum latency
        ext_ready_i = 1'b1; ext_rdata_i = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        ext_ready_i = 1'b0; ext_rdata_i = '0;
        check("late_rdy_resp", 32'(bus.mem_rvalid_o | bus.mem_err_o), 32'd0);
        check("late_rdy_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.push_back(32'hCAFE_F00D);
        issue("ext_min", 1'b0, 32'h0000_2040, 4'hF, 32'h0);
        ext_ready_i = 1'b1; ext_rdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        ext_ready_i = 1'b0; ext_rdata_i = '0;
        wait_resp("ext_min", 2, 2, 1'b0, 1'b1);

        // Unmapped, misaligned and window-end boundary
        issue("unmapped_0", 1'b0, 32'h0000_0000, 4'hF, 32'h0);
        wait_resp("unmapped_0", 1, 1, 1'b1, 1'b0);
        issue("misalign_101", 1'b0, 32'h0000_0101, 4'hF, 32'h0);
        wait_resp("misalign_101", 1, 1, 1'b1, 1'b0);
        issue("ext_end", 1'b0, 32'h0100_2000, 4'hF, 32'h0);
        wait_resp("ext_end", 1, 1, 1'b1, 1'b0);

        // Timer
        issue("timer_wr", 1'b1, 32'h0000_0200, 4'hF, 32'h0000_0064);
        check("timer_set", 32'(timer_set_o), 32'd1);
        check("timer_val", timer_val_o, 32'h0000_0064);
        wait_resp("timer_wr", 1, 1, 1'b0, 1'b0);
        check("timer_set_pulse", 32'(timer_set_o), 32'd0);
        timer_high_i = 1'b1;
        exp_q.push_back(32'h0000_0001);
        issue("timer_rd", 1'b0, 32'h0000_0200, 4'hF, 32'h0);
        wait_resp("timer_rd", 1, 1, 1'b0, 1'b1);
        timer_high_i = 1'b0;

        // Reset in EXT_WAIT: outputs clear at once and the response is dropped
        issue("ext_rst", 1'b0, 32'h0000_2080, 4'hF, 32'h0);
        check("ext_rst_req", 32'(ext_req_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ext",   32'(ext_req_o), 32'd0);
        check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mid_oe",    32'(gpio_oe_o), 32'd0);
        check("rst_mid_out",   32'(gpio_out_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_resp = 0;
        for (int i = 0; i < 6; i++) begin
            n_resp += int'(bus.mem_rvalid_o | bus.mem_err_o);
            @(posedge clk); #1;
        end
        check("rst_no_resp", 32'(n_resp), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
